// File: rtl/erg_pkg.sv
// Shared definitions for the erg stroke-timing blocks: phase encoding and
// measurement-sequence states.
package erg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DRIVE    = 2'b01,
        RECOVERY = 2'b10
    } phase_t;

    typedef enum logic [1:0] {
        MEAS_NONE  = 2'b00,  // no tick seen since reset/timeout
        MEAS_FIRST = 2'b01,  // one tick seen, timing started
        MEAS_RUN   = 2'b10   // reference period held, ticks are compared
    } meas_t;

endpackage

// File: rtl/stroke_phase_detector_edge_sync.sv
// Two-flop synchronizer for the asynchronous flywheel sensor followed by a
// registered rising-edge detector producing a one-cycle tick.
module edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Synchronize, keep one delayed copy, and register the rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            sync3 <= sync2;
            pulse <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/stroke_phase_detector.sv
// Flywheel stroke phase detector: measures tick-to-tick periods, tracks
// acceleration/deceleration streaks and steps IDLE/DRIVE/RECOVERY.
module stroke_phase_detector
    import erg_pkg::*;
#(
    parameter int PERIOD_W = 32,
    parameter int CONFIRM  = 3,
    parameter int HYST     = 2,
    parameter int TIMEOUT  = 50_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sensor_in,
    output logic                start_drive,
    output logic                start_recovery,
    output logic [1:0]          phase,
    output logic [15:0]         stroke_count,
    output logic [PERIOD_W-1:0] period_out
);

    localparam int                SW        = $clog2(CONFIRM + 1);
    localparam logic [SW-1:0]     CONF_S    = SW'(CONFIRM);
    localparam logic [PERIOD_W:0] HYST_X    = (PERIOD_W + 1)'(HYST);
    localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);

    logic                tick;
    phase_t              phase_q, phase_d;
    meas_t               meas_q, meas_d;
    logic [SW-1:0]       accel_q, accel_d, accel_inc;
    logic [SW-1:0]       decel_q, decel_d, decel_inc;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] prev_q, prev_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [15:0]         stroke_q, stroke_d;
    logic                sd_q, sd_d;
    logic                sr_q, sr_d;
    logic                is_accel;
    logic                is_decel;

    edge_sync u_edge_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (sensor_in),
        .pulse    (tick)
    );

    // Comparisons widened by one bit so the hysteresis sum cannot wrap.
    assign is_accel  = ({1'b0, cnt_q} + HYST_X) < {1'b0, prev_q};
    assign is_decel  = {1'b0, cnt_q} > ({1'b0, prev_q} + HYST_X);
    assign accel_inc = (accel_q == CONF_S) ? accel_q : accel_q + SW'(1);
    assign decel_inc = (decel_q == CONF_S) ? decel_q : decel_q + SW'(1);

    // Next-state: interval counting, measurement sequence, streaks, phase.
    always_comb begin
        phase_d  = phase_q;
        meas_d   = meas_q;
        accel_d  = accel_q;
        decel_d  = decel_q;
        prev_d   = prev_q;
        period_d = period_q;
        stroke_d = stroke_q;
        sd_d     = 1'b0;
        sr_d     = 1'b0;
        cnt_d    = cnt_q;

        if (tick) begin
            cnt_d = PERIOD_W'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end

        if (tick) begin
            case (meas_q)
                MEAS_NONE: begin
                    meas_d = MEAS_FIRST;
                end
                MEAS_FIRST: begin
                    prev_d   = cnt_q;
                    period_d = cnt_q;
                    meas_d   = MEAS_RUN;
                end
                default: begin
                    prev_d   = cnt_q;
                    period_d = cnt_q;
                    if (is_accel) begin
                        accel_d = accel_inc;
                        decel_d = '0;
                        if (phase_q != DRIVE && accel_inc == CONF_S) begin
                            phase_d  = DRIVE;
                            accel_d  = '0;
                            sd_d     = 1'b1;
                            stroke_d = stroke_q + 16'd1;
                        end
                    end else if (is_decel) begin
                        decel_d = decel_inc;
                        accel_d = '0;
                        if (phase_q == DRIVE && decel_inc == CONF_S) begin
                            phase_d = RECOVERY;
                            decel_d = '0;
                            sr_d    = 1'b1;
                        end
                    end
                end
            endcase
        end else if (cnt_q == TIMEOUT_C) begin
            // Idle flywheel: forget the stroke, keep the reported values.
            phase_d = IDLE;
            meas_d  = MEAS_NONE;
            accel_d = '0;
            decel_d = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q  <= IDLE;
            meas_q   <= MEAS_NONE;
            accel_q  <= '0;
            decel_q  <= '0;
            cnt_q    <= '0;
            prev_q   <= '0;
            period_q <= '0;
            stroke_q <= '0;
            sd_q     <= 1'b0;
            sr_q     <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            meas_q   <= meas_d;
            accel_q  <= accel_d;
            decel_q  <= decel_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            period_q <= period_d;
            stroke_q <= stroke_d;
            sd_q     <= sd_d;
            sr_q     <= sr_d;
        end
    end

    assign start_drive    = sd_q;
    assign start_recovery = sr_q;
    assign phase          = phase_q;
    assign stroke_count   = stroke_q;
    assign period_out     = period_q;

endmodule

// File: tb/tb_stroke_phase_detector.sv
// Self-checking bench for stroke_phase_detector: directed stroke sequences
// plus randomized tick gaps, checked every cycle against an event-level model.
module tb_stroke_phase_detector;

    localparam int PW   = 16;
    localparam int CONF = 3;
    localparam int HY   = 2;
    localparam int TO   = 1000;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          sensor_in = 1'b0;
    logic          start_drive;
    logic          start_recovery;
    logic [1:0]    phase;
    logic [15:0]   stroke_count;
    logic [PW-1:0] period_out;

    stroke_phase_detector #(
        .PERIOD_W (PW),
        .CONFIRM  (CONF),
        .HYST     (HY),
        .TIMEOUT  (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sensor_in      (sensor_in),
        .start_drive    (start_drive),
        .start_recovery (start_recovery),
        .phase          (phase),
        .stroke_count   (stroke_count),
        .period_out     (period_out)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state (event level: ticks and their periods).
    int      m_phase   = 0;
    int      m_seq     = 0;
    int      m_acc     = 0;
    int      m_dec     = 0;
    int      m_prev    = 0;
    int      m_pout    = 0;
    int      m_strokes = 0;
    bit      m_sd      = 1'b0;
    bit      m_sr      = 1'b0;
    longint  cyc       = 0;
    longint  last_edge = 0;
    bit      last_valid = 1'b0;
    bit      s_prev    = 1'b0;
    bit [2:0] hist     = 3'b000;
    bit      due;
    bit      rise;

    function automatic void apply_tick(input int per);
        if (m_seq == 0) begin
            m_seq = 1;
        end else if (m_seq == 1) begin
            m_prev = per;
            m_pout = per;
            m_seq  = 2;
        end else begin
            if (per + HY < m_prev) begin
                m_acc = (m_acc < CONF) ? m_acc + 1 : CONF;
                m_dec = 0;
                if (m_phase != 1 && m_acc == CONF) begin
                    m_phase   = 1;
                    m_acc     = 0;
                    m_dec     = 0;
                    m_sd      = 1'b1;
                    m_strokes = (m_strokes + 1) % 65536;
                end
            end else if (per > m_prev + HY) begin
                m_dec = (m_dec < CONF) ? m_dec + 1 : CONF;
                m_acc = 0;
                if (m_phase == 1 && m_dec == CONF) begin
                    m_phase = 2;
                    m_acc   = 0;
                    m_dec   = 0;
                    m_sr    = 1'b1;
                end
            end
            m_prev = per;
            m_pout = per;
        end
    endfunction

    // Model: a sensor rise seen at edge E takes effect on the outputs at E+3.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_seq = 0; m_acc = 0; m_dec = 0;
            m_prev = 0; m_pout = 0; m_strokes = 0;
            m_sd = 1'b0; m_sr = 1'b0;
            last_valid = 1'b0; s_prev = 1'b0; hist = 3'b000;
        end else begin
            cyc++;
            m_sd = 1'b0;
            m_sr = 1'b0;
            rise   = sensor_in && !s_prev;
            s_prev = sensor_in;
            due    = hist[2];
            hist   = {hist[1:0], rise};
            if (due) begin
                apply_tick(int'(cyc - last_edge));
                last_edge  = cyc;
                last_valid = 1'b1;
            end else if (last_valid && (cyc - last_edge == TO)) begin
                m_phase = 0;
                m_acc   = 0;
                m_dec   = 0;
                m_seq   = 0;
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        check_eq("phase",       32'(phase),          m_phase);
        check_eq("start_drive", 32'(start_drive),    32'(m_sd));
        check_eq("start_rec",   32'(start_recovery), 32'(m_sr));
        check_eq("strokes",     32'(stroke_count),   m_strokes);
        check_eq("period_out",  32'(period_out),     m_pout);
        check_eq("pulse_excl",  32'(start_drive & start_recovery), 32'd0);
    end

    // One sensor rise (held 1..3 cycles), then wait so the next rise is p cycles later.
    task automatic send(input int p);
        int w;
        w = (p > 4) ? int'($urandom_range(1, 3)) : 1;
        sensor_in = 1'b1;
        repeat (w) @(negedge clk);
        sensor_in = 1'b0;
        repeat (p - w) @(negedge clk);
    endtask

    task automatic check_state(input string tag, input int ph, input int st, input int po);
        check_eq({tag, "_phase"},  32'(phase),        ph);
        check_eq({tag, "_stroke"}, 32'(stroke_count), st);
        check_eq({tag, "_period"}, 32'(period_out),   po);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_phase"},  32'(phase),          32'd0);
        check_eq({tag, "_sd"},     32'(start_drive),    32'd0);
        check_eq({tag, "_sr"},     32'(start_recovery), 32'd0);
        check_eq({tag, "_stroke"}, 32'(stroke_count),   32'd0);
        check_eq({tag, "_period"}, 32'(period_out),     32'd0);
    endtask

    int seq_a[5] = '{100, 90, 80, 70, 80};
    int seq_b[5] = '{81, 82, 90, 100, 90};
    int seq_c[9] = '{80, 70, 80, 90, 85, 95, 105, 115, 105};
    int seq_d[3] = '{95, 85, 1100};
    int seq_e[8] = '{100, 90, 80, 70, 80, 90, 100, 20};

    initial begin
        int p;
        int dir;
        int run;
        int use_p;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        foreach (seq_a[i]) send(seq_a[i]);
        check_state("first_drive", 1, 1, 70);
        foreach (seq_b[i]) send(seq_b[i]);
        check_state("neutral_recov", 2, 1, 100);
        foreach (seq_c[i]) send(seq_c[i]);
        check_state("broken_decel", 2, 2, 115);
        foreach (seq_d[i]) send(seq_d[i]);
        check_state("timeout", 0, 3, 85);
        foreach (seq_e[i]) send(seq_e[i]);
        check_state("after_timeout", 2, 4, 100);

        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_zero("mid_reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        p   = 120;
        dir = -1;
        run = 0;
        for (int unsigned k = 0; k < 250; k++) begin
            if (run == 0) begin
                dir = -dir;
                run = int'($urandom_range(4, 8));
            end
            run--;
            p = p + dir * int'($urandom_range(0, 15));
            if (p < 20)  p = 20;
            if (p > 400) p = 400;
            use_p = p;
            case ($urandom_range(0, 29))
                0: use_p = TO;
                1: use_p = TO + 1;
                2: use_p = TO - 1;
                default: use_p = p;
            endcase
            if (k == 125) begin
                @(posedge clk);
                #2 reset_n = 1'b0;
                #1 check_zero("rand_reset");
                @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
            end
            send(use_p);
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
